// File: rtl/rhd_spi_frame_engine_if.sv
// Signal bundle between the RHD SPI frame engine and its neighbours: the MOSI
// command selector, the RHD chip pins, and the downstream FIFO/packer.
interface rhd_spi_frame_engine_if;
  logic        run;
  logic [15:0] MOSI_cmd;
  logic        MISO;
  logic [5:0]  channel;
  logic        CS_b;
  logic        SCLK;
  logic        MOSI;
  logic [15:0] miso_word;
  logic        miso_valid;
  logic [5:0]  miso_channel;
  logic        frame_done;
  logic [31:0] timestamp;
  logic        busy;

  modport master (
    input  run,
    input  MOSI_cmd,
    input  MISO,
    output channel,
    output CS_b,
    output SCLK,
    output MOSI,
    output miso_word,
    output miso_valid,
    output miso_channel,
    output frame_done,
    output timestamp,
    output busy
  );

  modport slave (
    output run,
    output MOSI_cmd,
    output MISO,
    input  channel,
    input  CS_b,
    input  SCLK,
    input  MOSI,
    input  miso_word,
    input  miso_valid,
    input  miso_channel,
    input  frame_done,
    input  timestamp,
    input  busy
  );
endinterface

// File: rtl/rhd_spi_frame_engine.sv
// RHD SPI frame engine: sequences channels, shifts each 16-bit command out on
// CS_b/SCLK/MOSI over an 80-cycle slot and returns the captured MISO word.
module rhd_spi_frame_engine #(
  parameter int NUM_CHANNELS = 35,
  parameter int MISO_DELAY   = 0
) (
  input logic                    dataclk,
  input logic                    reset,
  rhd_spi_frame_engine_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [6:0] SLOT_LAST  = 7'd79;
  localparam logic [5:0] CHAN_LAST  = 6'(NUM_CHANNELS - 1);
  localparam logic [6:0] SAMP_FIRST = 7'(8 + MISO_DELAY);
  localparam logic [6:0] SAMP_LAST  = 7'(68 + MISO_DELAY);

  state_t      state_r;
  state_t      state_s;
  logic [6:0]  slot_r;
  logic [6:0]  slot_s;
  logic [5:0]  channel_r;
  logic [5:0]  channel_s;

  logic [15:0] shift_r;
  logic [15:0] cap_r;
  logic [15:0] cap_s;
  logic        cs_b_r;
  logic        sclk_r;
  logic        mosi_r;
  logic [15:0] miso_word_r;
  logic        miso_valid_r;
  logic [5:0]  miso_channel_r;
  logic        frame_done_r;
  logic [31:0] timestamp_r;
  logic        busy_r;

  logic        slot_end_s;
  logic        slot_fire_s;
  logic        frame_fire_s;
  logic        sample_s;
  logic        active_s;
  logic        cs_b_s;
  logic        sclk_s;
  logic        mosi_s;
  logic [3:0]  bit_idx_s;

  // State, slot counter and channel index registers.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      slot_r    <= 7'd0;
      channel_r <= 6'd0;
    end else begin
      state_r   <= state_s;
      slot_r    <= slot_s;
      channel_r <= channel_s;
    end
  end

  // Next-state logic; DRAIN lingers for the cycle that presents the last slot's result.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    channel_s  = channel_r;
    slot_end_s = (slot_r == SLOT_LAST);
    case (state_r)
      ST_IDLE: begin
        slot_s    = 7'd0;
        channel_s = 6'd0;
        if (bus.run) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE, ST_DRAIN: begin
        if ((state_r == ST_DRAIN) && frame_done_r) begin
          state_s   = ST_IDLE;
          slot_s    = 7'd0;
          channel_s = 6'd0;
        end else begin
          if ((state_r == ST_ACTIVE) && !bus.run) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = state_r;
          end
          if (slot_end_s) begin
            slot_s = 7'd0;
            if (channel_r == CHAN_LAST) begin
              channel_s = 6'd0;
            end else begin
              channel_s = channel_r + 6'd1;
            end
          end else begin
            slot_s = slot_r + 7'd1;
          end
        end
      end
      default: begin
        state_s   = ST_IDLE;
        slot_s    = 7'd0;
        channel_s = 6'd0;
      end
    endcase
  end

  // Slot events and MISO capture shift.
  always_comb begin
    slot_fire_s  = (state_r != ST_IDLE) && slot_end_s;
    frame_fire_s = slot_fire_s && (channel_r == CHAN_LAST);
    sample_s     = (state_r != ST_IDLE) &&
                   (slot_r >= SAMP_FIRST) && (slot_r <= SAMP_LAST) &&
                   (((slot_r - SAMP_FIRST) & 7'd3) == 7'd0);
    if (sample_s) begin
      cap_s = {cap_r[14:0], bus.MISO};
    end else begin
      cap_s = cap_r;
    end
  end

  // Pin values for the upcoming cycle, so the SPI pins come straight from flops.
  always_comb begin
    active_s  = (state_s != ST_IDLE);
    bit_idx_s = 4'd15 - 4'((slot_s - 7'd6) >> 2);
    if (active_s && (slot_s >= 7'd4) && (slot_s <= 7'd71)) begin
      cs_b_s = 1'b0;
    end else begin
      cs_b_s = 1'b1;
    end
    if (active_s && (slot_s >= 7'd8) && (slot_s <= 7'd69) && !slot_s[1]) begin
      sclk_s = 1'b1;
    end else begin
      sclk_s = 1'b0;
    end
    if (active_s && (slot_s >= 7'd6) && (slot_s <= 7'd69)) begin
      mosi_s = shift_r[bit_idx_s];
    end else begin
      mosi_s = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      shift_r        <= 16'd0;
      cap_r          <= 16'd0;
      cs_b_r         <= 1'b1;
      sclk_r         <= 1'b0;
      mosi_r         <= 1'b0;
      miso_word_r    <= 16'd0;
      miso_valid_r   <= 1'b0;
      miso_channel_r <= 6'd0;
      frame_done_r   <= 1'b0;
      timestamp_r    <= 32'd0;
      busy_r         <= 1'b0;
    end else begin
      // The selector has had the whole s=0 cycle to settle on the new channel.
      if ((state_r != ST_IDLE) && (slot_r == 7'd1)) begin
        shift_r <= bus.MOSI_cmd;
      end else begin
        shift_r <= shift_r;
      end
      if (slot_fire_s || (state_r == ST_IDLE)) begin
        cap_r <= 16'd0;
      end else begin
        cap_r <= cap_s;
      end
      cs_b_r       <= cs_b_s;
      sclk_r       <= sclk_s;
      mosi_r       <= mosi_s;
      miso_valid_r <= slot_fire_s;
      frame_done_r <= frame_fire_s;
      busy_r       <= active_s;
      if (slot_fire_s) begin
        miso_word_r    <= cap_s;
        miso_channel_r <= channel_r;
      end else if (!active_s) begin
        miso_word_r    <= 16'd0;
        miso_channel_r <= 6'd0;
      end else begin
        miso_word_r    <= miso_word_r;
        miso_channel_r <= miso_channel_r;
      end
      if (frame_fire_s) begin
        timestamp_r <= timestamp_r + 32'd1;
      end else begin
        timestamp_r <= timestamp_r;
      end
    end
  end

  assign bus.channel      = channel_r;
  assign bus.CS_b         = cs_b_r;
  assign bus.SCLK         = sclk_r;
  assign bus.MOSI         = mosi_r;
  assign bus.miso_word    = miso_word_r;
  assign bus.miso_valid   = miso_valid_r;
  assign bus.miso_channel = miso_channel_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.timestamp    = timestamp_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_rhd_spi_frame_engine.sv
// Scoreboard bench for rhd_spi_frame_engine: loopback MISO, directed frames,
// drain, mid-slot reset and late MOSI_cmd change.
module tb_rhd_spi_frame_engine;
  logic        dataclk  = 1'b0;
  logic        reset    = 1'b1;
  logic        sel_mode = 1'b0;
  logic [15:0] cmd_hold = 16'h0000;
  int          cyc      = 0;
  int          checks   = 0;
  int          errors   = 0;
  int          st       = 0;

  typedef struct {
    logic [15:0] word;
    logic [5:0]  chan;
    logic        fdone;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q2[$];
  logic [15:0] mq[$];
  exp_t        e0;
  exp_t        e2;

  rhd_spi_frame_engine_if if0 ();
  rhd_spi_frame_engine_if if2 ();

  rhd_spi_frame_engine #(.NUM_CHANNELS(35), .MISO_DELAY(0)) dut0 (
    .dataclk (dataclk),
    .reset   (reset),
    .bus     (if0.master)
  );

  rhd_spi_frame_engine #(.NUM_CHANNELS(35), .MISO_DELAY(2)) dut2 (
    .dataclk (dataclk),
    .reset   (reset),
    .bus     (if2.master)
  );

  // Selector model: a distinct command per channel.
  function automatic logic [15:0] sel_word(input logic [5:0] c);
    return {4'b1001, c, 6'b010101};
  endfunction

  assign if0.MOSI_cmd = sel_mode ? sel_word(if0.channel) : cmd_hold;
  assign if0.MISO     = if0.MOSI;
  assign if2.MOSI_cmd = 16'hA5C3;
  assign if2.MISO     = if2.MOSI;

  always #5 dataclk = ~dataclk;
  always @(posedge dataclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge dataclk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (if0.busy && n < budget) begin
      @(negedge dataclk);
      n++;
    end
    checks++;
    if (if0.busy) begin
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", budget);
    end
    repeat (2) @(negedge dataclk);
  endtask

  // Result monitor for the MISO_DELAY=0 instance.
  always @(negedge dataclk) begin
    if (if0.frame_done) begin
      checks++;
      if (!if0.miso_valid) begin
        errors++;
        $display("FAIL frame_done_alone0: miso_valid=0 at cycle %0d, want 1", cyc);
      end
    end
    if (if0.miso_valid) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid0: word=%h chan=%0d cycle=%0d, want no pulse",
                 if0.miso_word, if0.miso_channel, cyc);
      end else begin
        e0 = q0.pop_front();
        if (if0.miso_word !== e0.word || if0.miso_channel !== e0.chan ||
            if0.frame_done !== e0.fdone || cyc != e0.cyc || if0.busy !== 1'b1) begin
          errors++;
          $display("FAIL slot0: got word=%h chan=%0d fd=%b cyc=%0d busy=%b, want word=%h chan=%0d fd=%b cyc=%0d busy=1",
                   if0.miso_word, if0.miso_channel, if0.frame_done, cyc, if0.busy,
                   e0.word, e0.chan, e0.fdone, e0.cyc);
        end
      end
    end
  end

  // Result monitor for the MISO_DELAY=2 instance.
  always @(negedge dataclk) begin
    if (if2.miso_valid) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid2: word=%h chan=%0d cycle=%0d, want no pulse",
                 if2.miso_word, if2.miso_channel, cyc);
      end else begin
        e2 = q2.pop_front();
        if (if2.miso_word !== e2.word || if2.miso_channel !== e2.chan ||
            if2.frame_done !== e2.fdone || cyc != e2.cyc) begin
          errors++;
          $display("FAIL slot2: got word=%h chan=%0d fd=%b cyc=%0d, want word=%h chan=%0d fd=%b cyc=%0d",
                   if2.miso_word, if2.miso_channel, if2.frame_done, cyc,
                   e2.word, e2.chan, e2.fdone, e2.cyc);
        end
      end
    end
  end

  // MOSI monitor: collects the bit on each SCLK rise within a CS_b window.
  logic        sclk_q = 1'b0;
  logic        cs_q   = 1'b1;
  logic [15:0] msh    = 16'h0000;
  int          mcnt   = 0;
  logic        mone   = 1'b0;
  logic [15:0] mw;
  always @(negedge dataclk) begin
    if (reset) begin
      mcnt <= 0;
      mone <= 1'b0;
    end else if (!if0.CS_b) begin
      if (if0.SCLK && !sclk_q) begin
        msh  <= {msh[14:0], if0.MOSI};
        mcnt <= mcnt + 1;
      end
      if (if0.MOSI) mone <= 1'b1;
    end else if (!cs_q) begin
      if (mcnt == 16) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL mosi_unexpected: got %h, want no window", msh);
        end else begin
          mw = mq.pop_front();
          if (msh !== mw || (mw == 16'h0000 && mone)) begin
            errors++;
            $display("FAIL mosi_word: got %h (any_one=%b), want %h", msh, mone, mw);
          end
        end
      end
      mcnt <= 0;
      mone <= 1'b0;
    end
    sclk_q <= if0.SCLK;
    cs_q   <= if0.CS_b;
  end

  initial begin
    if0.run = 1'b0;
    if2.run = 1'b0;
    repeat (3) @(negedge dataclk);
    chk("rst_cs_b",      32'(if0.CS_b),       32'd1);
    chk("rst_sclk",      32'(if0.SCLK),       32'd0);
    chk("rst_mosi",      32'(if0.MOSI),       32'd0);
    chk("rst_channel",   32'(if0.channel),    32'd0);
    chk("rst_valid",     32'(if0.miso_valid), 32'd0);
    chk("rst_busy",      32'(if0.busy),       32'd0);
    chk("rst_timestamp", if0.timestamp,       32'd0);
    reset = 1'b0;
    repeat (3) @(negedge dataclk);
    chk("idle_busy", 32'(if0.busy), 32'd0);
    chk("idle_cs_b", 32'(if0.CS_b), 32'd1);

    // Loopback A5C3 on both instances, run dropped in slot 10.
    @(negedge dataclk);
    st       = cyc + 1;
    cmd_hold = 16'hA5C3;
    if0.run  = 1'b1;
    if2.run  = 1'b1;
    for (int j = 0; j < 35; j++) begin
      q0.push_back('{16'hA5C3, 6'(j), 1'(j == 34), st + 80 * (j + 1)});
      q2.push_back('{16'h4B86, 6'(j), 1'(j == 34), st + 80 * (j + 1)});
      mq.push_back(16'hA5C3);
    end
    wait_cyc(st + 840);
    if0.run = 1'b0;
    if2.run = 1'b0;
    wait_idle(3000);
    chk("drain_cs_b",      32'(if0.CS_b),    32'd1);
    chk("drain_channel",   32'(if0.channel), 32'd0);
    chk("drain_timestamp", if0.timestamp,    32'd1);
    chk("delay2_timestamp", if2.timestamp,   32'd1);
    chk("drain_q0_empty",  32'(q0.size()),   32'd0);
    chk("drain_q2_empty",  32'(q2.size()),   32'd0);
    chk("drain_mq_empty",  32'(mq.size()),   32'd0);

    // Reset at s=40 of slot 5.
    @(negedge dataclk);
    st       = cyc + 1;
    cmd_hold = 16'h1234;
    if0.run  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      q0.push_back('{16'h1234, 6'(j), 1'b0, st + 80 * (j + 1)});
      mq.push_back(16'h1234);
    end
    wait_cyc(st + 440);
    chk("midslot_cs_b", 32'(if0.CS_b), 32'd0);
    reset   = 1'b1;
    if0.run = 1'b0;
    @(negedge dataclk);
    chk("abort_cs_b",      32'(if0.CS_b),       32'd1);
    chk("abort_sclk",      32'(if0.SCLK),       32'd0);
    chk("abort_channel",   32'(if0.channel),    32'd0);
    chk("abort_valid",     32'(if0.miso_valid), 32'd0);
    chk("abort_timestamp", if0.timestamp,       32'd0);
    reset = 1'b0;
    repeat (3) @(negedge dataclk);
    chk("abort_q0_empty", 32'(q0.size()), 32'd0);
    chk("abort_mq_empty", 32'(mq.size()), 32'd0);

    // Two full frames with per-channel commands.
    @(negedge dataclk);
    st       = cyc + 1;
    sel_mode = 1'b1;
    if0.run  = 1'b1;
    for (int j = 0; j < 70; j++) begin
      q0.push_back('{sel_word(6'(j % 35)), 6'(j % 35), 1'((j % 35) == 34), st + 80 * (j + 1)});
      mq.push_back(sel_word(6'(j % 35)));
    end
    wait_cyc(st + 3800);
    if0.run = 1'b0;
    wait_idle(3000);
    chk("frames_timestamp", if0.timestamp,    32'd2);
    chk("frames_channel",   32'(if0.channel), 32'd0);
    chk("frames_q0_empty",  32'(q0.size()),   32'd0);
    chk("frames_mq_empty",  32'(mq.size()),   32'd0);

    // Command changes to FFFF after the latch point of slot 0.
    @(negedge dataclk);
    st       = cyc + 1;
    sel_mode = 1'b0;
    cmd_hold = 16'h0000;
    if0.run  = 1'b1;
    q0.push_back('{16'h0000, 6'd0, 1'b0, st + 80});
    mq.push_back(16'h0000);
    for (int j = 1; j < 35; j++) begin
      q0.push_back('{16'hFFFF, 6'(j), 1'(j == 34), st + 80 * (j + 1)});
      mq.push_back(16'hFFFF);
    end
    wait_cyc(st + 20);
    cmd_hold = 16'hFFFF;
    if0.run  = 1'b0;
    wait_idle(3000);
    chk("late_cmd_timestamp", if0.timestamp,  32'd3);
    chk("late_cmd_q0_empty",  32'(q0.size()), 32'd0);
    chk("late_cmd_mq_empty",  32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
